// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial pattern transmitter, MSB first, repeated frames with idle gaps
module pattern_tx #(
    parameter int                   PAT_WIDTH   = 4,
    parameter logic [PAT_WIDTH-1:0] PATTERN     = 4'b1101,
    parameter int                   GAP_LEN     = 1,
    parameter int                   COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] repeat_cnt,
    output logic                   o,
    output logic                   o_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = $clog2(PAT_WIDTH);
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [IDX_W-1:0]       IDX_TOP  = IDX_W'(PAT_WIDTH - 1);
    localparam logic [GAP_W-1:0]       GAP_TOP  = GAP_W'(GAP_LEN - 1);
    localparam logic [COUNT_WIDTH-1:0] ONE_LEFT = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state, state_d;
    logic [IDX_W-1:0]       bit_idx, bit_idx_d;
    logic [GAP_W-1:0]       gap_cnt, gap_cnt_d;
    logic [COUNT_WIDTH-1:0] frames_left, frames_left_d;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            bit_idx     <= '0;
            gap_cnt     <= '0;
            frames_left <= '0;
            o           <= 1'b0;
            o_valid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            bit_idx     <= bit_idx_d;
            gap_cnt     <= gap_cnt_d;
            frames_left <= frames_left_d;
            // outputs are registered from the next state so they line up with it
            o           <= (state_d == SEND) ? PATTERN[bit_idx_d] : 1'b0;
            o_valid     <= (state_d == SEND);
            busy        <= (state_d == SEND) || (state_d == GAP);
            done        <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d       = state;
        bit_idx_d     = bit_idx;
        gap_cnt_d     = gap_cnt;
        frames_left_d = frames_left;
        case (state)
            IDLE: begin
                if (start) begin
                    if (repeat_cnt != '0) begin
                        state_d       = SEND;
                        frames_left_d = repeat_cnt;
                        bit_idx_d     = IDX_TOP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEND: begin
                if (bit_idx == '0) begin
                    frames_left_d = frames_left - 1'b1;
                    if (frames_left == ONE_LEFT) begin
                        state_d = DONE;
                    end else if (GAP_LEN == 0) begin
                        bit_idx_d = IDX_TOP;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_TOP;
                    end
                end else begin
                    bit_idx_d = bit_idx - 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_d   = SEND;
                    bit_idx_d = IDX_TOP;
                end else begin
                    gap_cnt_d = gap_cnt - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
